// File: rtl/sha256d_nonce_scheduler_if.sv
// Launch / word-request bus between the nonce scheduler (master) and sha256d_wrapper (slave).
// Handshake: slave holds s_rq with s_addr; master answers with a one-cycle s_rdy carrying s_data,
// then ignores s_rq for one guard cycle; s_start and s_done are single-cycle pulses.
interface sha256d_nonce_scheduler_if;
   logic         s_start;
   logic         s_rdy;
   logic [31:0]  s_data;
   logic [4:0]   s_addr;
   logic         s_rq;
   logic         s_done;
   logic [255:0] s_hash;

   modport master (output s_start, s_rdy, s_data, input s_addr, s_rq, s_done, s_hash);
   modport slave  (input s_start, s_rdy, s_data, output s_addr, s_rq, s_done, s_hash);
endinterface

// File: rtl/sha256d_nonce_scheduler.sv
// Walks sha256d_wrapper over a nonce range, serving header/nonce words and checking each
// result's leading-zero difficulty; stops on hit, range exhaustion or abort.
module sha256d_nonce_scheduler #(
   parameter int HDR_BYTES = 76,
   parameter int NONCE_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_we_i,
   input  logic [6:0]             cfg_addr_i,
   input  logic [7:0]             cfg_data_i,
   input  logic                   go_i,
   input  logic                   abort_i,
   input  logic [NONCE_W-1:0]     nonce_first_i,
   input  logic [NONCE_W-1:0]     nonce_last_i,
   input  logic [7:0]             zeros_req_i,
   sha256d_nonce_scheduler_if.master s_bus,
   output logic                   busy_o,
   output logic                   found_o,
   output logic                   exhausted_o,
   output logic [NONCE_W-1:0]     nonce_out_o,
   output logic [255:0]           hash_out_o,
   output logic [31:0]            attempts_o,
   output logic [2:0]             state_o
);
   localparam int HDR_WORDS = HDR_BYTES / 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_SERVE  = 3'd2,
      S_CHECK  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t               state_q;
   logic [7:0]           hdr_q [HDR_BYTES];
   logic [NONCE_W-1:0]   nonce_q, last_q, nonce_out_q;
   logic [7:0]           zeros_q;
   logic [255:0]         hash_q, hash_out_q;
   logic [31:0]          attempts_q, s_data_q;
   logic                 s_start_q, s_rdy_q, guard_q;
   logic                 busy_q, found_q, exhausted_q;
   logic [31:0]          nonce32, word_d;
   logic [6:0]           base;
   logic [8:0]           lz;
   logic                 serve_rq;

   function automatic logic [8:0] lead_zeros(input logic [255:0] h);
      logic [8:0] n;
      n = 9'd256;
      for (int i = 0; i < 256; i++) begin
         if (h[i]) n = 9'(255 - i);
      end
      return n;
   endfunction

   // The header store survives reset so a host can reload only what changed.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == S_IDLE && cfg_we_i && cfg_addr_i < 7'(HDR_BYTES))
         hdr_q[cfg_addr_i] <= cfg_data_i;
   end

   assign nonce32 = 32'(nonce_q);

   always_comb begin
      base   = {s_bus.s_addr, 2'b00};
      word_d = '0;
      if (s_bus.s_addr < 5'(HDR_WORDS))
         word_d = {hdr_q[base], hdr_q[base | 7'd1], hdr_q[base | 7'd2], hdr_q[base | 7'd3]};
      else if (s_bus.s_addr == 5'(HDR_WORDS))
         word_d = {nonce32[7:0], nonce32[15:8], nonce32[23:16], nonce32[31:24]};
   end

   assign lz       = lead_zeros(hash_q);
   assign serve_rq = (state_q == S_SERVE || state_q == S_DRAIN) &&
                     s_bus.s_rq && !s_rdy_q && !guard_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         s_start_q   <= 1'b0;
         s_rdy_q     <= 1'b0;
         guard_q     <= 1'b0;
         s_data_q    <= '0;
         nonce_q     <= '0;
         last_q      <= '0;
         zeros_q     <= '0;
         hash_q      <= '0;
         busy_q      <= 1'b0;
         found_q     <= 1'b0;
         exhausted_q <= 1'b0;
         nonce_out_q <= '0;
         hash_out_q  <= '0;
         attempts_q  <= '0;
      end else begin
         s_start_q <= 1'b0;
         s_rdy_q   <= 1'b0;
         guard_q   <= s_rdy_q;
         if (serve_rq) begin
            s_data_q <= word_d;
            s_rdy_q  <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (go_i && !abort_i) begin
                  nonce_q     <= nonce_first_i;
                  last_q      <= nonce_last_i;
                  zeros_q     <= zeros_req_i;
                  found_q     <= 1'b0;
                  exhausted_q <= 1'b0;
                  attempts_q  <= '0;
                  busy_q      <= 1'b1;
                  s_start_q   <= 1'b1;
                  state_q     <= S_LAUNCH;
               end
            end
            S_LAUNCH: state_q <= S_SERVE;
            S_SERVE: begin
               if (s_bus.s_done) begin
                  attempts_q <= attempts_q + 32'd1;
                  hash_q     <= s_bus.s_hash;
                  state_q    <= S_CHECK;
               end else if (abort_i) begin
                  state_q <= S_DRAIN;
               end
            end
            S_CHECK: begin
               if (abort_i) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (lz >= {1'b0, zeros_q}) begin
                  found_q     <= 1'b1;
                  nonce_out_q <= nonce_q;
                  hash_out_q  <= hash_q;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else if (nonce_q == last_q) begin
                  exhausted_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  nonce_q   <= nonce_q + 1'b1;
                  s_start_q <= 1'b1;
                  state_q   <= S_LAUNCH;
               end
            end
            // The wrapper cannot be cancelled, so its last hash is waited out and dropped.
            S_DRAIN: begin
               if (s_bus.s_done) begin
                  attempts_q <= attempts_q + 32'd1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign s_bus.s_start = s_start_q;
   assign s_bus.s_rdy   = s_rdy_q;
   assign s_bus.s_data  = s_data_q;
   assign busy_o        = busy_q;
   assign found_o       = found_q;
   assign exhausted_o   = exhausted_q;
   assign nonce_out_o   = nonce_out_q;
   assign hash_out_o    = hash_out_q;
   assign attempts_o    = attempts_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Directed bench: a behavioural sha256d_wrapper stand-in fetches words and returns hashes.
module tb_sha256d_nonce_scheduler;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we;
   logic [6:0]    cfg_addr;
   logic [7:0]    cfg_data;
   logic          go, abort;
   logic [31:0]   nonce_first, nonce_last;
   logic [7:0]    zeros_req;
   logic          busy, found, exhausted;
   logic [31:0]   nonce_out, attempts;
   logic [255:0]  hash_out;
   logic [2:0]    state;

   always #5 clk = ~clk;

   sha256d_nonce_scheduler_if bus();

   sha256d_nonce_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
      .go_i(go), .abort_i(abort),
      .nonce_first_i(nonce_first), .nonce_last_i(nonce_last), .zeros_req_i(zeros_req),
      .s_bus(bus),
      .busy_o(busy), .found_o(found), .exhausted_o(exhausted),
      .nonce_out_o(nonce_out), .hash_out_o(hash_out), .attempts_o(attempts),
      .state_o(state)
   );

   // Wrapper side is driven either by the model or by manual stimulus.
   bit            model_en;
   logic          m_rq, m_done, man_rq, man_done;
   logic [4:0]    m_addr, man_addr;
   logic [255:0]  m_hash;
   assign bus.s_rq   = model_en ? m_rq   : man_rq;
   assign bus.s_addr = model_en ? m_addr : man_addr;
   assign bus.s_done = model_en ? m_done : man_done;
   assign bus.s_hash = model_en ? m_hash : 256'h0;

   int            n_checks, n_errors;
   logic [7:0]    hdr_m [76];
   logic [31:0]   exp_q[$];
   logic [31:0]   rx_words [20];
   int            words_rx, n_starts;
   logic [31:0]   hit_nonce, last_nonce;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   function automatic logic [255:0] hash_for(input logic [31:0] n);
      if (n == hit_nonce) return {12'h000, 1'b1, 211'h0, n};
      return {1'b1, 223'h0, n};
   endfunction

   initial begin : wrapper_model
      bit got;
      m_rq = 1'b0; m_addr = '0; m_done = 1'b0; m_hash = '0;
      forever begin
         @(negedge clk);
         if (model_en && bus.s_start) begin
            n_starts++;
            words_rx = 0;
            for (int k = 0; k < 20; k++) begin
               m_addr = 5'(k);
               m_rq   = 1'b1;
               got    = 1'b0;
               for (int t = 0; t < 12 && !got; t++) begin
                  @(negedge clk);
                  if (bus.s_rdy) got = 1'b1;
               end
               chk("rdy_wait", 256'(got), 256'(1));
               rx_words[k] = bus.s_data;
               words_rx++;
               if (k < 19) begin
                  chk("hdr_word", 256'(bus.s_data),
                      256'({hdr_m[4*k], hdr_m[4*k+1], hdr_m[4*k+2], hdr_m[4*k+3]}));
               end else begin
                  chk("nonce_expected", 256'(exp_q.size() > 0), 256'(1));
                  if (exp_q.size() > 0) chk("nonce_word", 256'(bus.s_data), 256'(exp_q.pop_front()));
               end
            end
            m_rq       = 1'b0;
            last_nonce = bswap(rx_words[19]);
            m_hash     = hash_for(last_nonce);
            m_done     = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
         end
      end
   end

   task automatic cfg_write(input logic [6:0] a, input logic [7:0] d, input bit take);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      if (take && a < 7'd76) hdr_m[a] = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic start_scan(input logic [31:0] f, input logic [31:0] l, input logic [7:0] z);
      @(negedge clk);
      nonce_first = f; nonce_last = l; zeros_req = z; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_idle(output logic [2:0] prev_state);
      bit ok;
      ok = 1'b0;
      prev_state = state;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         prev_state = state;
      end
      chk("idle_timeout", 256'(ok), 256'(1));
   endtask

   task automatic push_range(input logic [31:0] f, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(bswap(f + 32'(i)));
   endtask

   initial begin : main
      logic [2:0] ps;
      int         cnt, starts0;
      bit         ok;
      n_checks = 0; n_errors = 0; n_starts = 0; words_rx = 0;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      go = 1'b0; abort = 1'b0; nonce_first = '0; nonce_last = '0; zeros_req = '0;
      man_rq = 1'b0; man_addr = '0; man_done = 1'b0; model_en = 1'b1;
      hit_nonce = 32'h0;
      for (int i = 0; i < 76; i++) hdr_m[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_found", 256'(found), 256'(0));
      chk("rst_attempts", 256'(attempts), 256'(0));
      chk("rst_state", 256'(state), 256'(0));
      chk("rst_s_data", 256'(bus.s_data), 256'(0));
      rst_n = 1'b1;

      // 1: header = byte index, single nonce, zero difficulty always hits
      for (int i = 0; i < 76; i++) cfg_write(7'(i), 8'(i), 1'b1);
      cfg_write(7'd100, 8'hEE, 1'b0);
      push_range(32'd5, 1);
      start_scan(32'd5, 32'd5, 8'd0);
      wait_idle(ps);
      chk("t1_word0", 256'(rx_words[0]), 256'(32'h00010203));
      chk("t1_word18", 256'(rx_words[18]), 256'(32'h48494A4B));
      chk("t1_word19", 256'(rx_words[19]), 256'(32'h05000000));
      chk("t1_found", 256'(found), 256'(1));
      chk("t1_nonce_out", 256'(nonce_out), 256'(32'd5));
      chk("t1_attempts", 256'(attempts), 256'(1));
      chk("t1_hash_out", hash_out, {1'b1, 223'h0, 32'd5});

      // Spurious s_done in IDLE and go together with abort are both ignored
      model_en = 1'b0;
      @(negedge clk); man_done = 1'b1;
      @(negedge clk); man_done = 1'b0;
      model_en = 1'b1;
      @(negedge clk); go = 1'b1; abort = 1'b1;
      @(negedge clk); go = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("idle_done_attempts", 256'(attempts), 256'(1));
      chk("go_abort_busy", 256'(busy), 256'(0));
      chk("go_abort_found", 256'(found), 256'(1));

      // 2: hit on the fourth nonce
      hit_nonce = 32'h1003;
      push_range(32'h1000, 4);
      start_scan(32'h1000, 32'h10FF, 8'd12);
      wait_idle(ps);
      chk("t2_found", 256'(found), 256'(1));
      chk("t2_exhausted", 256'(exhausted), 256'(0));
      chk("t2_nonce_out", 256'(nonce_out), 256'(32'h1003));
      chk("t2_attempts", 256'(attempts), 256'(4));
      chk("t2_hash_out", hash_out, {12'h000, 1'b1, 211'h0, 32'h1003});
      chk("t2_prev_check", 256'(ps), 256'(3));
      chk("t2_state_idle", 256'(state), 256'(0));
      chk("t2_queue_empty", 256'(exp_q.size()), 256'(0));

      // 3: wrapping range never hits
      hit_nonce = 32'h5555;
      push_range(32'hFFFF_FFFE, 4);
      start_scan(32'hFFFF_FFFE, 32'h0000_0001, 8'd255);
      wait_idle(ps);
      chk("t3_exhausted", 256'(exhausted), 256'(1));
      chk("t3_found", 256'(found), 256'(0));
      chk("t3_attempts", 256'(attempts), 256'(4));
      chk("t3_last_nonce", 256'(last_nonce), 256'(32'h1));
      chk("t3_queue_empty", 256'(exp_q.size()), 256'(0));

      // 4: abort while serving; store writes during the scan are dropped
      push_range(32'd0, 1);
      words_rx = 0;
      starts0 = n_starts;
      start_scan(32'd0, 32'd100, 8'd255);
      cfg_write(7'd0, 8'hAA, 1'b0);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (words_rx >= 3) ok = 1'b1;
      end
      chk("t4_reach_3_words", 256'(ok), 256'(1));
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      wait_idle(ps);
      chk("t4_words_served", 256'(words_rx), 256'(20));
      chk("t4_found", 256'(found), 256'(0));
      chk("t4_exhausted", 256'(exhausted), 256'(0));
      chk("t4_attempts", 256'(attempts), 256'(1));
      repeat (40) @(negedge clk);
      chk("t4_no_relaunch", 256'(n_starts - starts0), 256'(1));
      chk("t4_still_idle", 256'(busy), 256'(0));

      // 5: request guard with s_rq held, then reset mid-scan
      cfg_write(7'd4, 8'h99, 1'b1);
      model_en = 1'b0;
      start_scan(32'h1234_5678, 32'h1234_5678, 8'd255);
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (state == 3'd2) ok = 1'b1;
         else @(negedge clk);
      end
      chk("t5_reach_serve", 256'(ok), 256'(1));
      man_addr = 5'd19; man_rq = 1'b1; cnt = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (bus.s_rdy) cnt++;
         if (i == 4) man_rq = 1'b0;
      end
      chk("t5_guard_pulses", 256'(cnt), 256'(2));
      chk("t5_nonce_word", 256'(bus.s_data), 256'(32'h7856_3412));
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_rst_busy", 256'(busy), 256'(0));
      chk("t5_rst_state", 256'(state), 256'(0));
      chk("t5_rst_s_data", 256'(bus.s_data), 256'(0));
      chk("t5_rst_attempts", 256'(attempts), 256'(0));
      chk("t5_rst_nonce_out", 256'(nonce_out), 256'(0));
      chk("t5_rst_hash_out", hash_out, 256'h0);
      chk("t5_rst_found", 256'(found), 256'(0));
      rst_n = 1'b1;
      model_en = 1'b1;
      push_range(32'd7, 1);
      start_scan(32'd7, 32'd7, 8'd0);
      wait_idle(ps);
      chk("t5_found", 256'(found), 256'(1));
      chk("t5_nonce_out", 256'(nonce_out), 256'(32'd7));
      chk("t5_attempts", 256'(attempts), 256'(1));
      chk("t5_word0_kept", 256'(rx_words[0]), 256'(32'h00010203));
      chk("t5_word1_updated", 256'(rx_words[1]), 256'(32'h99050607));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
